// File: rtl/gf_poly_eval.sv
// Horner evaluation of a GF(2^6) polynomial (field x^6+x+1) at a captured point.
// Symbols arrive highest degree first; products come from an external multiplier controller.
module gf_poly_eval #(
    parameter int N_SYM = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [5:0] point,
    input  logic       sym_valid,
    input  logic [5:0] sym_data,
    output logic       sym_ready,
    output logic       busy,
    output logic       done,
    output logic [5:0] result,
    output logic       mul_start,
    output logic [5:0] mul_x,
    output logic [5:0] mul_y,
    input  logic       mul_ready,
    input  logic [5:0] mul_z
);

    localparam logic [5:0] NSYM = 6'(N_SYM);

    typedef enum logic [2:0] {IDLE, WAIT_SYM, MUL_REQ, MUL_WAIT, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] acc_q, acc_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] pt_q, pt_d;
    logic [5:0] hold_q, hold_d;
    logic [5:0] result_q, result_d;
    logic       mw_first_q, mw_first_d;
    logic       last_sym;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pt_d       = pt_q;
        hold_d     = hold_q;
        mw_first_d = 1'b0;
        sym_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mul_start  = 1'b0;
        mul_x      = '0;
        mul_y      = '0;
        last_sym   = (cnt_q + 6'd1 == NSYM);

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pt_d    = point;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = WAIT_SYM;
                end
            end
            WAIT_SYM: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    hold_d = sym_data;
                    if (cnt_q != NSYM) cnt_d = cnt_q + 6'd1;
                    // acc*point is zero for the first symbol, acc=0 or point=0: skip the multiplier
                    if (cnt_q == '0 || acc_q == '0 || pt_q == '0) begin
                        acc_d = sym_data;
                        if (last_sym) state_d = DONE;
                    end else begin
                        state_d = MUL_REQ;
                    end
                end
            end
            MUL_REQ: begin
                mul_start  = 1'b1;
                mul_x      = acc_q;
                mul_y      = pt_q;
                mw_first_d = 1'b1;
                state_d    = MUL_WAIT;
            end
            MUL_WAIT: begin
                mul_x = acc_q;
                mul_y = pt_q;
                // the multiplier's ready flag is stale in the cycle right after mul_start
                if (!mw_first_q && mul_ready) begin
                    acc_d   = mul_z ^ hold_q;
                    state_d = (cnt_q == NSYM) ? DONE : WAIT_SYM;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase

        result_d = (state_d == DONE) ? acc_d : result_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            pt_q       <= '0;
            hold_q     <= '0;
            result_q   <= '0;
            mw_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pt_q       <= pt_d;
            hold_q     <= hold_d;
            result_q   <= result_d;
            mw_first_q <= mw_first_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_gf_poly_eval.sv
// Bench for gf_poly_eval: four instances (N_SYM 3, 7, 2, 1) driven from one stimulus process,
// a latency-randomised multiplier model, and a scoreboard fed by a Horner reference model.
module tb_gf_poly_eval;

    localparam int NI = 4;

    function automatic int nsym_of(input int k);
        case (k)
            0:       return 3;
            1:       return 7;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    typedef struct {
        logic [5:0] res;
        int         nmul;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start_s     [NI];
    logic [5:0] point_s     [NI];
    logic       sym_valid_s [NI];
    logic [5:0] sym_data_s  [NI];
    logic       sym_ready_s [NI];
    logic       busy_s      [NI];
    logic       done_s      [NI];
    logic [5:0] result_s    [NI];
    logic       mul_start_s [NI];
    logic [5:0] mul_x_s     [NI];
    logic [5:0] mul_y_s     [NI];
    logic       mul_ready_s [NI];
    logic [5:0] mul_z_s     [NI];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   donecnt [NI] = '{default: 0};
    int   mulcnt  [NI] = '{default: 0};
    int   gap     [NI] = '{default: 99};
    int   phase   [NI];
    int   rem     [NI];
    logic [5:0] capx [NI];
    logic [5:0] capy [NI];
    bit   deliver [NI];
    bit   rst_abort = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        gf_poly_eval #(.N_SYM(nsym_of(gi))) u_dut (
            .clk       (clk),
            .resetN    (resetN),
            .start     (start_s[gi]),
            .point     (point_s[gi]),
            .sym_valid (sym_valid_s[gi]),
            .sym_data  (sym_data_s[gi]),
            .sym_ready (sym_ready_s[gi]),
            .busy      (busy_s[gi]),
            .done      (done_s[gi]),
            .result    (result_s[gi]),
            .mul_start (mul_start_s[gi]),
            .mul_x     (mul_x_s[gi]),
            .mul_y     (mul_y_s[gi]),
            .mul_ready (mul_ready_s[gi]),
            .mul_z     (mul_z_s[gi])
        );
    end

    // Carry-less product reduced modulo x^6+x+1 (0x43).
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (12'(a) << i);
        for (int i = 11; i >= 6; i--) if (p[i]) p = p ^ (12'h043 << (i - 6));
        return p[5:0];
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Multiplier controller: ready stays high (stale) through the cycle after mul_start,
    // carrying a wrong product, then the real product appears after 0..3 extra cycles.
    initial begin
        for (int k = 0; k < NI; k++) begin
            mul_ready_s[k] = 1'b1;
            mul_z_s[k]     = 6'($urandom);
            phase[k]       = 0;
            deliver[k]     = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                deliver[k] = 1'b0;
                case (phase[k])
                    0: if (mul_start_s[k]) begin
                        capx[k]    = mul_x_s[k];
                        capy[k]    = mul_y_s[k];
                        mul_z_s[k] = gf_mul(capx[k], capy[k]) ^ 6'h15;
                        phase[k]   = 1;
                    end
                    1: begin
                        rem[k]   = int'($urandom_range(0, 3));
                        phase[k] = 2;
                    end
                    default: if (rem[k] == 0) begin
                        mul_ready_s[k] = 1'b1;
                        mul_z_s[k]     = gf_mul(capx[k], capy[k]);
                        deliver[k]     = 1'b1;
                        phase[k]       = 0;
                    end else begin
                        mul_ready_s[k] = 1'b0;
                        rem[k]--;
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse and watches the multiplier handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (mul_start_s[k]) begin
                    mulcnt[k]++;
                    chk("mul_start_spacing", int'(gap[k] >= 2), 1);
                    gap[k] = 0;
                end else if (gap[k] < 1000) begin
                    gap[k]++;
                end
                if (deliver[k] && !rst_abort)
                    chk("mul_operands_stable", int'({mul_x_s[k], mul_y_s[k]}), int'({capx[k], capy[k]}));
                if (done_s[k]) begin
                    donecnt[k]++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", int'(result_s[k]), int'(e.res));
                        chk("mul_count", mulcnt[k], e.nmul);
                    end
                    mulcnt[k] = 0;
                end else if (!busy_s[k]) begin
                    mulcnt[k] = 0;
                end
            end
        end
    end

    // Entered and left on a falling edge.
    task automatic run_eval(input int k, input logic [5:0] pt, input logic [5:0] syms [64],
                            input bit stall, input bit xs);
        int         n;
        int         nmul;
        int         d0;
        int         guard;
        bit         last_mul;
        logic [5:0] acc;
        exp_t       e;
        n        = nsym_of(k);
        acc      = '0;
        nmul     = 0;
        last_mul = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && acc != '0 && pt != '0) begin
                nmul++;
                last_mul = (i == n - 1);
            end
            acc = gf_mul(acc, pt) ^ syms[i];
        end
        e.res  = acc;
        e.nmul = nmul;
        exp_q.push_back(e);
        d0 = donecnt[k];

        start_s[k] = 1'b1;
        point_s[k] = pt;
        @(negedge clk);
        start_s[k] = 1'b0;
        point_s[k] = 6'($urandom);
        chk("busy_after_start", int'(busy_s[k]), 1);

        for (int i = 0; i < n; i++) begin
            if ((stall || xs) && i == n / 2) begin
                sym_valid_s[k] = 1'b0;
                if (xs) begin
                    start_s[k] = 1'b1;
                    point_s[k] = 6'($urandom);
                    @(negedge clk);
                    start_s[k] = 1'b0;
                end
                if (stall) repeat (5) @(negedge clk);
            end
            sym_valid_s[k] = 1'b1;
            sym_data_s[k]  = syms[i];
            guard = 0;
            while (!sym_ready_s[k] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                chk("sym_ready_timeout", 0, 1);
                sym_valid_s[k] = 1'b0;
                return;
            end
            @(negedge clk);
            sym_valid_s[k] = 1'b0;
            sym_data_s[k]  = 6'($urandom);
            if (i == n - 1 && !last_mul) chk("done_one_cycle_after_last", int'(done_s[k]), 1);
        end

        guard = 0;
        while (donecnt[k] == d0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (donecnt[k] == d0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("result_hold", int'(result_s[k]), int'(acc));
        chk("one_done_pulse", donecnt[k] - d0, 1);
        chk("idle_after_done", int'(busy_s[k]), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] syms [64];
        logic [5:0] pt;
        int         ksel;
        int         d0;
        int         guard;

        resetN = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_s[k]     = 1'b0;
            point_s[k]     = '0;
            sym_valid_s[k] = 1'b0;
            sym_data_s[k]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk("reset_outputs", int'({busy_s[k], done_s[k], sym_ready_s[k], mul_start_s[k],
                                       mul_x_s[k], mul_y_s[k], result_s[k]}), 0);
        resetN = 1'b1;
        @(negedge clk);

        syms    = '{default: '0};
        syms[0] = 6'h01;
        run_eval(0, 6'h02, syms, 1'b0, 1'b0);   // 0x04 expected
        run_eval(1, 6'h02, syms, 1'b0, 1'b0);   // x^6 reduces to 0x03
        syms[0] = 6'h05;
        syms[1] = 6'h03;
        run_eval(2, 6'h00, syms, 1'b0, 1'b0);   // point 0: 0x03, no multiply
        syms[0] = 6'h2A;
        run_eval(3, 6'($urandom), syms, 1'b0, 1'b0);
        syms    = '{default: '0};
        syms[0] = 6'h01;
        run_eval(0, 6'h02, syms, 1'b1, 1'b1);   // stalled stream plus stray start

        // Reset in MUL_WAIT, then let the late mul_ready arrive.
        rst_abort  = 1'b1;
        d0         = donecnt[0];
        start_s[0] = 1'b1;
        point_s[0] = 6'h02;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sym_valid_s[0] = 1'b1;
            sym_data_s[0]  = (i == 0) ? 6'h01 : 6'h00;
            guard = 0;
            while (!sym_ready_s[0] && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
        end
        sym_valid_s[0] = 1'b0;
        chk("mul_req_after_sym", int'(mul_start_s[0]), 1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("abort_outputs", int'({busy_s[0], done_s[0], sym_ready_s[0], mul_start_s[0],
                                   mul_x_s[0], mul_y_s[0], result_s[0]}), 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("late_ready_outputs", int'({busy_s[0], done_s[0], sym_ready_s[0], mul_start_s[0],
                                        mul_x_s[0], mul_y_s[0], result_s[0]}), 0);
        chk("abort_no_done", donecnt[0] - d0, 0);
        rst_abort = 1'b0;
        @(negedge clk);
        run_eval(0, 6'h02, syms, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            ksel = int'($urandom_range(0, NI - 1));
            pt   = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
            for (int i = 0; i < 64; i++)
                syms[i] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
            run_eval(ksel, pt, syms, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_poly_eval.md
GF_POLY_EVAL -- requirements
Module: gf_poly_eval

Interface
REQ-001 Parameter N_SYM, default 8, SHALL be the number of codeword symbols per evaluation; the legal range is 1..63.
REQ-002 clk  in  1  SHALL be the single clock; every flop SHALL update on its rising edge.
REQ-003 resetN  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  in  1  SHALL request a new evaluation; it is sampled only while busy=0.
REQ-005 point  in  6  SHALL be the GF(2^6) evaluation point, captured when start is accepted.
REQ-006 sym_valid  in  1 / sym_data  in  6 / sym_ready  out  1  SHALL be the symbol stream, highest-degree symbol first.
REQ-007 busy  out  1  SHALL be high from start acceptance until done.
REQ-008 done  out  1  SHALL be a one-cycle pulse marking result valid.
REQ-009 result  out  6  SHALL hold the polynomial value at point.
REQ-010 mul_start  out  1 / mul_x  out  6 / mul_y  out  6  SHALL be the request port to the GF(2^6) multiplier controller.
REQ-011 mul_ready  in  1 / mul_z  in  6  SHALL be that controller's completion flag and product.

Function
REQ-012 The block SHALL compute the Horner recurrence: acc = acc*point XOR sym, over GF(2^6) with field polynomial x^6+x+1.
- Addition is bitwise XOR.
- Multiplication is performed only by the external multiplier.
REQ-013 The FSM SHALL have the states IDLE, WAIT_SYM, MUL_REQ, MUL_WAIT and DONE; any illegal state SHALL go to IDLE.
REQ-014 IDLE with start=1 SHALL capture point, clear acc and the symbol counter, and go to WAIT_SYM.
REQ-015 sym_ready SHALL be high only in WAIT_SYM; a symbol transfers on a cycle with sym_valid=1 and sym_ready=1.
REQ-016 On transfer of the first symbol, acc SHALL load sym_data directly and no multiply is issued.
REQ-017 On transfer of a later symbol, the block SHALL register sym_data.
- If acc=0 or point=0: acc SHALL become the held symbol on the next edge, with no multiply.
- Otherwise: the FSM SHALL go to MUL_REQ.
REQ-018 MUL_REQ SHALL hold mul_start=1 for exactly one cycle, with mul_x=acc and mul_y=point, then go to MUL_WAIT.
REQ-019 mul_x and mul_y SHALL stay stable from mul_start until the product is taken; mul_start SHALL be 0 in every other state.
REQ-020 In MUL_WAIT, mul_ready SHALL be ignored in the first cycle after mul_start, because the multiplier's flag is stale there.
REQ-021 From the second cycle onward, mul_ready=1 SHALL load acc = mul_z XOR held symbol and return to WAIT_SYM, or go to DONE if the counter has reached N_SYM.
REQ-022 Between two mul_start pulses there SHALL be at least two low cycles, as required by the multiplier's edge-detected start.
REQ-023 After N_SYM symbols have transferred and no multiply is pending, the FSM SHALL enter DONE.
- In DONE, result=acc and done=1 for one cycle.
- The FSM then returns to IDLE.
REQ-024 result SHALL hold its value until the next DONE; start arriving while busy=1 SHALL be ignored and not queued.
REQ-025 When N_SYM=1, DONE SHALL follow the single transfer with no multiply.
REQ-026 With an immediately ready stream and no multiply skips, per-symbol latency SHALL be 2 + multiplier latency cycles.
REQ-027 The symbol counter SHALL be 6 bits wide, saturating at N_SYM, and SHALL NOT wrap.

Reset
REQ-028 While resetN=0, state SHALL be IDLE and all of the following SHALL be 0: acc, counter, point register, held symbol, result, busy, done, sym_ready, mul_start, mul_x, mul_y.
REQ-029 Reset asserted mid-evaluation, including during MUL_WAIT, SHALL abort immediately with no done pulse.
REQ-030 After reset, a late mul_ready SHALL NOT alter acc, because it is ignored outside MUL_WAIT.

Verification
REQ-031 N_SYM=3, point=0x02, symbols 0x01,0x00,0x00 -> exactly two mul_start pulses; result=0x04; one done pulse.
REQ-032 N_SYM=7, point=0x02, symbols 0x01 then six 0x00 -> result=0x03 (x^6 reduction); six multiplies.
REQ-033 N_SYM=2, point=0x00, symbols 0x05,0x03 -> result=0x03; mul_start never asserted.
REQ-034 N_SYM=1, symbol 0x2A -> result=0x2A one cycle after the transfer; no multiply.
REQ-035 A second start while busy, plus sym_valid held low for 5 cycles mid-stream -> start ignored; result still correct (0x04 for REQ-031 stimulus).
REQ-036 resetN pulsed low during MUL_WAIT, then mul_ready=1 -> all outputs 0; FSM in IDLE; no done pulse; a subsequent evaluation is correct.
